// File: rtl/bp_pkg.sv
// Shared definitions for the branch-prediction update path: counter encoding,
// update-FSM state encoding, saturating counter helpers and the layout of the
// record held in the update FIFO.
// Optional feature macro: BP_UPD_STATS_EN (adds pred_taken to the record).
package bp_pkg;

  // 2-bit direction counter
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Update FSM
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;

  // Record layout, MSB to LSB: {pc, target[AW-1:2], taken [, pred_taken]}
`ifdef BP_UPD_STATS_EN
  localparam int REC_PRED_W = 1;
`else
  localparam int REC_PRED_W = 0;
`endif

  function automatic int rec_width(input int aw);
    return aw + (aw - 2) + 1 + REC_PRED_W;
  endfunction

  function automatic int rec_taken_bit();
    return REC_PRED_W;
  endfunction

  function automatic int rec_tgt_lsb();
    return REC_PRED_W + 1;
  endfunction

  function automatic int rec_pc_lsb(input int aw);
    return REC_PRED_W + 1 + (aw - 2);
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small synchronous FIFO holding resolved-branch records. Pointers carry an
// extra wrap bit so full and empty are distinguishable without a counter.
// A push while full is dropped, even if a pop happens in the same cycle.
module bp_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_count = r_wr - r_rd;
  assign o_head  = r_mem[r_rd[AW-1:0]];

  // Pointer update; reset discards every queued record
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/bp_update_unit.sv
// Write-side controller for the branch prediction cache. Buffers resolved
// branches, then for each one reads the cache line (LOOKUP), and issues a
// single write from registered lookup results (WRITE). Because the write
// lands at the end of WRITE, the next LOOKUP always sees fresh contents.
// Optional feature macro: BP_UPD_STATS_EN (update/alloc/mispredict counters).
module bp_update_unit
  import bp_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [AWIDTH-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [AWIDTH-1:0] upd_target,
  input  logic              upd_pred_taken,
  output logic [AWIDTH-1:0] rd_addr,
  input  logic [DWIDTH-1:0] rd_data,
  input  logic              rd_hit,
  output logic [AWIDTH-1:0] wa,
  output logic [DWIDTH-1:0] din,
  output logic              we,
  output logic              busy
`ifdef BP_UPD_STATS_EN
  ,
  output logic [31:0]       stat_updates,
  output logic [31:0]       stat_allocs,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int RW      = rec_width(AWIDTH);
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int TK_BIT  = rec_taken_bit();
  localparam int TGT_LSB = rec_tgt_lsb();
  localparam int PC_LSB  = rec_pc_lsb(AWIDTH);

  logic [1:0]        r_state;
  logic              r_hit;
  logic              r_taken;
  logic [DWIDTH-1:0] r_data;
  logic [AWIDTH-1:0] r_pc;
  logic [AWIDTH-3:0] r_tgt;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [RW-1:0]     w_rec;
  logic [RW-1:0]     w_head;
  logic [AWIDTH-1:0] w_head_pc;
  logic [AWIDTH-3:0] w_head_tgt;
  logic              w_head_taken;
  logic              w_in_write;
  logic              w_wr_req;
  logic [DWIDTH-1:0] w_din;

`ifdef BP_UPD_STATS_EN
  logic              r_pred;
  logic              w_unused_bits;
  assign w_rec         = {upd_pc, upd_target[AWIDTH-1:2], upd_taken, upd_pred_taken};
  assign w_unused_bits = ^upd_target[1:0];
`else
  logic              w_unused_bits;
  assign w_rec         = {upd_pc, upd_target[AWIDTH-1:2], upd_taken};
  assign w_unused_bits = ^{upd_pred_taken, upd_target[1:0]};
`endif

  assign upd_ready = !w_full;
  assign w_push    = upd_valid && !w_full;
  assign w_pop     = (r_state == ST_WRITE);

  bp_upd_fifo #(.DEPTH(DEPTH), .WIDTH(RW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_rec),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head_pc    = w_head[PC_LSB +: AWIDTH];
  assign w_head_tgt   = w_head[TGT_LSB +: AWIDTH-2];
  assign w_head_taken = w_head[TK_BIT];

  assign rd_addr = (r_state == ST_LOOKUP) ? w_head_pc : '0;
  assign busy    = !w_empty || (r_state != ST_IDLE);

  // Write data from the registered lookup; miss + not-taken writes nothing
  always_comb begin
    w_wr_req = 1'b0;
    w_din    = '0;
    if (r_hit) begin
      w_wr_req = 1'b1;
      if (r_taken) w_din = {(DWIDTH-2)'(r_tgt), sat_inc(r_data[1:0])};
      else         w_din = {r_data[DWIDTH-1:2], sat_dec(r_data[1:0])};
    end else if (r_taken) begin
      w_wr_req = 1'b1;
      w_din    = {(DWIDTH-2)'(r_tgt), CTR_WT};
    end
  end

  // Reset masks the write port combinationally so an in-flight write dies
  assign w_in_write = (r_state == ST_WRITE) && !reset;
  assign we  = w_in_write && w_wr_req;
  assign wa  = w_in_write ? r_pc  : '0;
  assign din = w_in_write ? w_din : '0;

  // IDLE -> LOOKUP -> WRITE, looping back to LOOKUP while records remain
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_hit   <= 1'b0;
      r_taken <= 1'b0;
      r_data  <= '0;
      r_pc    <= '0;
      r_tgt   <= '0;
`ifdef BP_UPD_STATS_EN
      r_pred  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (!w_empty) r_state <= ST_LOOKUP;
        ST_LOOKUP: begin
          r_hit   <= rd_hit;
          r_data  <= rd_data;
          r_pc    <= w_head_pc;
          r_tgt   <= w_head_tgt;
          r_taken <= w_head_taken;
`ifdef BP_UPD_STATS_EN
          r_pred  <= w_head[0];
`endif
          r_state <= ST_WRITE;
        end
        ST_WRITE: r_state <= (w_count > CW'(1) || w_push) ? ST_LOOKUP : ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef BP_UPD_STATS_EN
  // Event counters, free-running with natural 32-bit wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_updates     <= '0;
      stat_allocs      <= '0;
      stat_mispredicts <= '0;
    end else if (w_pop) begin
      stat_updates <= stat_updates + 32'd1;
      if (!r_hit && r_taken) stat_allocs <= stat_allocs + 32'd1;
      if (r_pred != r_taken) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_update_unit.sv
// Self-checking bench for bp_update_unit: a behavioural cache answers the
// read port and absorbs writes; expected writes go to a scoreboard queue
// when each record is pushed and are matched as we pulses appear.
module tb_bp_update_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        upd_valid = 1'b0;
  logic        upd_taken = 1'b0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [31:0] upd_target = '0;
  logic        upd_ready, rd_hit, we, busy;
  logic [31:0] rd_addr, rd_data, wa, din;

  always #5 clk = ~clk;

  bp_update_unit #(.AWIDTH(32), .DWIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_hit(rd_hit), .wa(wa), .din(din), .we(we), .busy(busy)
  );

  // Direct-mapped cache model, index = addr[11:2], full-address tag
  logic        cv   [1024];
  logic [31:0] ctag [1024];
  logic [31:0] cdat [1024];
  logic        pl_en = 1'b0, pl_v = 1'b0;
  logic [31:0] pl_addr = '0, pl_data = '0;

  always_comb begin
    rd_hit  = cv[rd_addr[11:2]] && (ctag[rd_addr[11:2]] == rd_addr);
    rd_data = cdat[rd_addr[11:2]];
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) cv[i] <= 1'b0;
    end else if (we) begin
      cv[wa[11:2]] <= 1'b1; ctag[wa[11:2]] <= wa; cdat[wa[11:2]] <= din;
    end else if (pl_en) begin
      cv[pl_addr[11:2]] <= pl_v; ctag[pl_addr[11:2]] <= pl_addr; cdat[pl_addr[11:2]] <= pl_data;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [31:0] wa; logic [31:0] din; } wr_t;
  wr_t exp_q[$];
  int  we_cyc_q[$];
  int  errors = 0;
  int  checks = 0;

  // Scoreboard: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (we) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got wa=%h din=%h, required no write", wa, din);
      end else begin
        e = exp_q.pop_front();
        if (wa !== e.wa || din !== e.din) begin
          errors++;
          $display("FAIL write_data: got wa=%h din=%h, required wa=%h din=%h", wa, din, e.wa, e.din);
        end
      end
      we_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic pre(input logic [31:0] a, input logic v, input logic [31:0] d);
    @(negedge clk); pl_en = 1'b1; pl_addr = a; pl_v = v; pl_data = d;
    @(negedge clk); pl_en = 1'b0;
  endtask

  // Drive one record; returns wait cycles and the cycle count seen just after acceptance
  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                      input logic exp_we, input logic [31:0] exp_din,
                      output int waits, output int acc);
    wr_t e;
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tg; upd_pred_taken = ~tk;
    waits = 0;
    while (!upd_ready && waits < 50) begin @(negedge clk); waits++; end
    if (!upd_ready) chk("push_ready_timeout", 32'(upd_ready), 32'd1);
    acc = cyc + 1;
    if (exp_we) begin e.wa = pc; e.din = exp_din; exp_q.push_back(e); end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk); upd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || exp_q.size() != 0) && n < 60);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_pending"}, exp_q.size(), 32'd0);
  endtask

  typedef struct {
    logic [31:0] pc; logic tk; logic [31:0] tg;
    logic pl_v; logic [31:0] pl_d; logic exp_we; logic [31:0] exp_din;
  } vec_t;
  vec_t vt[10];

  initial begin
    int w, ac;
    int wq[6];
    vt[0] = '{32'h100, 1'b1, 32'h200, 1'b0, 32'h0,    1'b1, 32'h202};
    vt[1] = '{32'h100, 1'b1, 32'h200, 1'b1, 32'h203,  1'b1, 32'h203};
    vt[2] = '{32'h100, 1'b0, 32'h200, 1'b1, 32'h200,  1'b1, 32'h200};
    vt[3] = '{32'h104, 1'b0, 32'h300, 1'b0, 32'h0,    1'b0, 32'h0};
    vt[4] = '{32'h108, 1'b1, 32'h300, 1'b1, 32'h201,  1'b1, 32'h302};
    vt[5] = '{32'h10C, 1'b0, 32'h0,   1'b1, 32'h202,  1'b1, 32'h201};
    vt[6] = '{32'h110, 1'b0, 32'h0,   1'b1, 32'h203,  1'b1, 32'h202};
    vt[7] = '{32'h114, 1'b1, 32'h204, 1'b1, 32'h200,  1'b1, 32'h205};
    vt[8] = '{32'h118, 1'b1, 32'h3FF, 1'b0, 32'h0,    1'b1, 32'h3FE};
    vt[9] = '{32'h11C, 1'b0, 32'h0,   1'b1, 32'h5551, 1'b1, 32'h5550};

    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    chk("rst_ready", 32'(upd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_wa", wa, 32'd0);
    chk("rst_din", din, 32'd0);
    chk("rst_rdaddr", rd_addr, 32'd0);

    // Single-record vectors: counter/target math, miss handling, latency
    for (int i = 0; i < 10; i++) begin
      pre(vt[i].pc, vt[i].pl_v, vt[i].pl_d);
      we_cyc_q.delete();
      push(vt[i].pc, vt[i].tk, vt[i].tg, vt[i].exp_we, vt[i].exp_din, w, ac);
      idle();
      wait_idle($sformatf("v%0d", i));
      chk($sformatf("v%0d_nwrites", i), we_cyc_q.size(), vt[i].exp_we ? 32'd1 : 32'd0);
      if (vt[i].exp_we && we_cyc_q.size() > 0)
        chk($sformatf("v%0d_latency", i), we_cyc_q[0], ac + 2);
      chk($sformatf("v%0d_ready", i), 32'(upd_ready), 32'd1);
    end

    // Burst of 6: FIFO fills after the 5th push, 6th held one cycle
    we_cyc_q.delete();
    for (int k = 0; k < 6; k++)
      push(32'h800 + 32'(4 * k), 1'b1, 32'h1000 + 32'(16 * k), 1'b1,
           (32'h1000 + 32'(16 * k)) | 32'h2, wq[k], ac);
    idle();
    wait_idle("burst");
    chk("burst_wait4", wq[4], 32'd0);
    chk("burst_wait5", wq[5], 32'd1);
    chk("burst_nwrites", we_cyc_q.size(), 32'd6);
    for (int k = 1; k < we_cyc_q.size(); k++)
      chk($sformatf("burst_gap%0d", k), we_cyc_q[k] - we_cyc_q[k-1], 32'd2);

    // Back-to-back updates to one PC: second lookup must see the first write
    pre(32'h40, 1'b1, 32'h81);
    push(32'h40, 1'b1, 32'h80, 1'b1, 32'h82, w, ac);
    push(32'h40, 1'b1, 32'h80, 1'b1, 32'h83, w, ac);
    idle();
    wait_idle("samepc");

    // Reset while WRITE is active with 3 records queued
    push(32'h900, 1'b1, 32'hA00, 1'b1, 32'hA02, w, ac);
    push(32'h904, 1'b1, 32'hA10, 1'b1, 32'hA12, w, ac);
    push(32'h908, 1'b1, 32'hA20, 1'b1, 32'hA22, w, ac);
    #1 upd_valid = 1'b0;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!we && n < 10);
      chk("rst_mid_reach_write", 32'(we), 32'd1);
    end
    #2 reset = 1'b1;
    #1 chk("rst_mid_we", 32'(we), 32'd0);
    exp_q.delete();
    we_cyc_q.delete();
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mid_nwrites", we_cyc_q.size(), 32'd0);
    chk("rst_mid_ready", 32'(upd_ready), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
